// File: rtl/mem_router_pkg.sv
// Shared types and default tables for the CPU-to-slave memory router.
package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam int DEF_NUM_SLAVES = 4;

  // Default map: bits 22:21 select one of four 2 MiB regions
  localparam logic [3:0][23:0] DEF_REGION_BASE = {24'h600000, 24'h400000, 24'h200000, 24'h000000};
  localparam logic [3:0][23:0] DEF_REGION_MASK = {4{24'h600000}};
  localparam logic [3:0][3:0]  DEF_WAIT_STATES = '0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_SLAVES);

endpackage

// File: rtl/mem_router_if.sv
// CPU-side and slave-side bus of the memory router; 'slave' is the router's view.
interface mem_router_if #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_W-1:0]            addr_i;
  logic                         re_i;
  logic                         we_i;
  logic [DATA_W-1:0]            data_i;
  logic [DATA_W-1:0]            data_o;
  logic                         needWait_o;
  logic                         err_o;
  logic [ADDR_W-1:0]            addr_o;
  logic [DATA_W-1:0]            wdata_o;
  logic [NUM_SLAVES-1:0]        re_o;
  logic [NUM_SLAVES-1:0]        we_o;
  logic [NUM_SLAVES*DATA_W-1:0] rdata_i;
  logic [NUM_SLAVES-1:0]        needWait_i;
  logic [7:0]                   err_count_o;

  modport slave (
    input  addr_i, re_i, we_i, data_i, rdata_i, needWait_i,
    output data_o, needWait_o, err_o, addr_o, wdata_o, re_o, we_o, err_count_o
  );

  modport master (
    output addr_i, re_i, we_i, data_i, rdata_i, needWait_i,
    input  data_o, needWait_o, err_o, addr_o, wdata_o, re_o, we_o, err_count_o
  );
endinterface

// File: rtl/mem_router_decode.sv
// Address decoder: lowest-index matching region wins; re and we together is a protocol error.
module mem_router_decode
  import mem_router_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  localparam int IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              proto_err
);

  // Scanning downwards lets the lowest matching index overwrite higher ones
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((addr & REGION_MASK[k]) == REGION_BASE[k]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

  assign proto_err = re & we;

endmodule

// File: rtl/mem_router.sv
// Memory router: decodes a CPU access onto one of NUM_SLAVES ports with wait states and timeout.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_SLAVES-1:0][3:0]        WAIT_STATES = DEF_WAIT_STATES,
  parameter int TIMEOUT_CYC = 255
) (
  input logic        clk,
  input logic        rst_n,
  mem_router_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_next;
  logic              req, hit, proto_err, op_we, slave_busy;
  logic [IDX_W-1:0]  dec_idx, sel;
  logic [3:0]        wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] rdata_q, slave_rdata;
  logic [7:0]        err_cnt;
  logic [NUM_SLAVES-1:0] strobe;

  assign req = bus.re_i | bus.we_i;

  mem_router_decode #(
    .ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES),
    .REGION_BASE(REGION_BASE), .REGION_MASK(REGION_MASK)
  ) u_decode (
    .addr(bus.addr_i), .re(bus.re_i), .we(bus.we_i),
    .hit(hit), .idx(dec_idx), .proto_err(proto_err)
  );

  assign slave_busy  = bus.needWait_i[sel];
  assign slave_rdata = bus.rdata_i[sel*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Completion wins over timeout when both fall on the same cycle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (req) state_next = (hit && !proto_err) ? ACCESS : ERR;
      ACCESS: begin
        if (wait_cnt == 4'd0 && !slave_busy)          state_next = DONE;
        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1))    state_next = ERR;
      end
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.addr_o  <= '0;
      bus.wdata_o <= '0;
      sel         <= '0;
      op_we       <= 1'b0;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      rdata_q     <= '0;
      err_cnt     <= '0;
    end else begin
      if (state == IDLE && req) begin
        bus.addr_o  <= bus.addr_i;
        bus.wdata_o <= bus.data_i;
        op_we       <= bus.we_i;
        sel         <= dec_idx;
        wait_cnt    <= WAIT_STATES[dec_idx];
        to_cnt      <= '0;
      end
      if (state == ACCESS) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        if (state_next == DONE && !op_we) rdata_q <= slave_rdata;
      end
      if (state != ERR && state_next == ERR && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once
  assign strobe          = (state == ACCESS) ? (NUM_SLAVES'(1) << sel) : '0;
  assign bus.re_o        = op_we ? '0 : strobe;
  assign bus.we_o        = op_we ? strobe : '0;
  assign bus.needWait_o  = req && !(state inside {DONE, ERR});
  assign bus.err_o       = (state == ERR);
  assign bus.data_o      = (state == ERR) ? '1 : rdata_q;
  assign bus.err_count_o = err_cnt;

endmodule

// File: tb/tb_mem_router.sv
// Randomized scoreboard bench for mem_router against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_router;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int NS  = 4;
  localparam int TOC = 8;
  // Map with an unmapped hole (0x8xxxxx) and an overlap at 0x4xxxxx that slave 2 must win
  localparam logic [NS-1:0][AW-1:0] BASE  = {24'h400000, 24'h400000, 24'h200000, 24'h000000};
  localparam logic [NS-1:0][AW-1:0] MASK  = {24'h400000, 24'hE00000, 24'h600000, 24'hE00000};
  localparam logic [NS-1:0][3:0]    WAITS = {4'd3, 4'd2, 4'd0, 4'd0};

  typedef struct {
    bit          err;
    int          lat;
    int          strobes;
    logic [NS-1:0] rd_mask;
    logic [NS-1:0] wr_mask;
    logic [DW-1:0] data;
    logic [7:0]  ecnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_router_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();

  mem_router #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS),
    .REGION_BASE(BASE), .REGION_MASK(MASK), .WAIT_STATES(WAITS),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int            m_errs = 0;
  logic [DW-1:0] m_last_read = '0;

  int            tgt = 0;
  int            stall_len = 0;
  logic [DW-1:0] tgt_rdata = '0;
  int            issue_id = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & MASK[k]) == BASE[k]) return k;
    return -1;
  endfunction

  // Slave model: the target stalls through its first stall_len strobe cycles, others are noise
  int seen = 0;
  int seen_id = -1;
  always @(negedge clk) begin : slave_model
    logic [NS-1:0]    nw;
    logic [NS*DW-1:0] rd;
    if (issue_id != seen_id) begin
      seen    = 0;
      seen_id = issue_id;
    end
    if (bus.re_o[tgt] || bus.we_o[tgt]) seen++;
    for (int k = 0; k < NS; k++) begin
      if (k == tgt) begin
        nw[k]          = (seen <= stall_len);
        rd[k*DW +: DW] = tgt_rdata;
      end else begin
        nw[k]          = 1'($urandom_range(0, 1));
        rd[k*DW +: DW] = 16'($urandom);
      end
    end
    bus.needWait_i = nw;
    bus.rdata_i    = rd;
  end

  // Monitor: counts request cycles and strobes, scores each completion against the queue head
  int mcyc = 0;
  int mstrobes = 0;
  bit mstrobe_ok = 1'b1;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n || !(bus.re_i || bus.we_i)) begin
      mcyc = 0; mstrobes = 0; mstrobe_ok = 1'b1;
    end else begin
      mcyc++;
      if ((bus.re_o | bus.we_o) != '0) begin
        mstrobes++;
        if (exp_q.size() == 0 || bus.re_o !== exp_q[0].rd_mask || bus.we_o !== exp_q[0].wr_mask)
          mstrobe_ok = 1'b0;
      end
      if (!bus.needWait_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("completion_has_expectation", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("latency",       32'(mcyc),       32'(e.lat));
          checkOutput("strobe_cycles", 32'(mstrobes),   32'(e.strobes));
          checkOutput("strobe_select", 32'(mstrobe_ok), 32'd1);
          checkOutput("err_o",         32'(bus.err_o),  32'(e.err));
          checkOutput("data_o",        32'(bus.data_o), 32'(e.data));
          checkOutput("err_count_o",   32'(bus.err_count_o), 32'(e.ecnt));
          checkOutput("addr_o",        32'(bus.addr_o), 32'(e.addr));
          checkOutput("wdata_o",       32'(bus.wdata_o), 32'(e.wdata));
        end
        mcyc = 0; mstrobes = 0; mstrobe_ok = 1'b1;
      end
    end
  end

  // Builds the expectation from the access rules, drives the request and holds it to completion
  task automatic applyStimulus(input logic [AW-1:0] addr, input bit re, input bit we,
                               input logic [DW-1:0] data, input int stall, input logic [DW-1:0] rd);
    exp_t e;
    int   k;
    int   len;
    bit   done;
    k         = decode(addr);
    e.addr    = addr;
    e.wdata   = data;
    e.rd_mask = '0;
    e.wr_mask = '0;
    if (k < 0 || (re && we)) begin
      e.err = 1'b1; e.lat = 2; e.strobes = 0; e.data = '1;
      k = 0;
    end else begin
      len = int'(WAITS[k]) + stall + 1;
      if (re) e.rd_mask = NS'(1) << k;
      else    e.wr_mask = NS'(1) << k;
      if (len > TOC) begin
        e.err = 1'b1; e.lat = TOC + 2; e.strobes = TOC; e.data = '1;
      end else begin
        e.err = 1'b0; e.lat = len + 2; e.strobes = len;
        if (re) m_last_read = rd;
        e.data = m_last_read;
      end
    end
    if (e.err && m_errs < 255) m_errs++;
    e.ecnt    = 8'(m_errs);
    tgt       = k;
    stall_len = int'(WAITS[k]) + stall;
    tgt_rdata = rd;
    issue_id++;
    exp_q.push_back(e);
    bus.addr_i = addr;
    bus.re_i   = re;
    bus.we_i   = we;
    bus.data_i = data;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!bus.needWait_o) done = 1'b1;
    end
    checkOutput("handshake_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    bus.re_i = 1'b0;
    bus.we_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int      r;
    logic [AW-1:0] a;
    bit      found;
    rst_n      = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.re_i   = 1'b0;
    bus.we_i   = 1'b0;

    #1 bus.re_i = 1'b1;
    #1 checkOutput("reset_needwait_with_req", 32'(bus.needWait_o), 32'd1);
    bus.re_i = 1'b0;
    #1;
    checkOutput("reset_needwait_idle", 32'(bus.needWait_o),  32'd0);
    checkOutput("reset_re_o",          32'(bus.re_o),        32'd0);
    checkOutput("reset_we_o",          32'(bus.we_o),        32'd0);
    checkOutput("reset_err_o",         32'(bus.err_o),       32'd0);
    checkOutput("reset_data_o",        32'(bus.data_o),      32'd0);
    checkOutput("reset_addr_o",        32'(bus.addr_o),      32'd0);
    checkOutput("reset_wdata_o",       32'(bus.wdata_o),     32'd0);
    checkOutput("reset_err_count_o",   32'(bus.err_count_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] directed accesses");
    applyStimulus(24'h200010, 1'b1, 1'b0, 16'h0000, 0, 16'hBEEF);
    idleCycles(1);
    applyStimulus(24'h600002, 1'b0, 1'b1, 16'h1234, 0, 16'h5A5A);
    idleCycles(1);
    applyStimulus(24'h000000, 1'b1, 1'b0, 16'h0000, 1000, 16'h1111);
    applyStimulus(24'h400100, 1'b1, 1'b0, 16'h0000, 1, 16'hC0DE);
    applyStimulus(24'h812345, 1'b0, 1'b1, 16'h7777, 0, 16'h0000);
    idleCycles(2);

    $display("[TB] random accesses");
    for (int i = 0; i < 150; i++) begin
      a = 24'($urandom);
      r = $urandom_range(0, 9);
      applyStimulus(a, (r <= 5), (r == 0 || r >= 6), 16'($urandom),
                    ($urandom_range(0, 19) == 0) ? 100 : $urandom_range(0, 3), 16'($urandom));
      if ($urandom_range(0, 2) != 0) idleCycles($urandom_range(1, 2));
    end
    idleCycles(1);

    $display("[TB] protocol errors to saturation");
    for (int i = 0; i < 300; i++)
      applyStimulus(24'($urandom), 1'b1, 1'b1, 16'($urandom), 0, 16'h0000);
    idleCycles(1);
    checkOutput("err_count_saturated", 32'(bus.err_count_o), 32'd255);

    $display("[TB] reset during access");
    rst_n = 1'b0;
    m_errs = 0;
    m_last_read = '0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    idleCycles(1);
    checkOutput("err_count_after_reset", 32'(bus.err_count_o), 32'd0);
    tgt = 0; stall_len = 1000; tgt_rdata = 16'h2222; issue_id++;
    bus.addr_i = 24'h000040;
    bus.re_i   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.re_o != '0) found = 1'b1;
    end
    checkOutput("abort_strobe_seen", 32'(bus.re_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_re_o",        32'(bus.re_o),        32'd0);
    checkOutput("abort_we_o",        32'(bus.we_o),        32'd0);
    checkOutput("abort_needwait",    32'(bus.needWait_o),  32'd1);
    checkOutput("abort_err_count_o", 32'(bus.err_count_o), 32'd0);
    checkOutput("abort_data_o",      32'(bus.data_o),      32'd0);
    bus.re_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idleCycles(3);
    checkOutput("post_abort_err_count_o", 32'(bus.err_count_o), 32'd0);
    checkOutput("post_abort_err_o",       32'(bus.err_o),       32'd0);
    checkOutput("post_abort_re_o",        32'(bus.re_o),        32'd0);

    applyStimulus(24'h200020, 1'b1, 1'b0, 16'h0000, 2, 16'h3C3C);
    idleCycles(2);
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
